ramp_table_writer: RTL and testbench

//  Producer side of the step-period FIFO that feeds the pulse controller. Computes a linear

---
 rtl/motor_pkg.sv | 18 +
 rtl/period_step_sat.sv | 30 +++
 rtl/ramp_table_writer.sv | 165 ++++++++++++++++
 tb/tb_ramp_table_writer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared encodings and width defaults for the step-period table path
package motor_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    localparam logic [1:0] MODE_ADCEL = 2'b01;
    localparam logic [1:0] MODE_UNIF  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCEL = 3'd1,
        ST_DECEL = 3'd2,
        ST_UNIF  = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

endpackage

// File: rtl/period_step_sat.sv
// rtl/period_step_sat.sv - one period step of +/- delta, clamped to a bound at DATA_W+1 bits
module period_step_sat #(
    parameter int W = 32
) (
    input  logic [W-1:0] cur_i,
    input  logic [W-1:0] delta_i,
    input  logic [W-1:0] bound_i,
    input  logic         up_i,
    output logic [W-1:0] next_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum  = {1'b0, cur_i} + {1'b0, delta_i};
        diff = {1'b0, cur_i} - {1'b0, delta_i};
        next_o = bound_i;
        if (up_i) begin
            // carry out means the true sum exceeds any W-bit ceiling
            if (!sum[W] && (sum[W-1:0] <= bound_i))
                next_o = sum[W-1:0];
        end else begin
            // borrow out means the true difference went negative
            if (!diff[W] && (diff[W-1:0] >= bound_i))
                next_o = diff[W-1:0];
        end
    end

endmodule

// File: rtl/ramp_table_writer.sv
// rtl/ramp_table_writer.sv - builds the accel/decel or uniform period table into the step FIFO
module ramp_table_writer
    import motor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] start_period,
    input  logic [DATA_W-1:0] min_period,
    input  logic [DATA_W-1:0] delta,
    input  logic [CNT_W-1:0]  accel_steps,
    input  logic [CNT_W-1:0]  decel_steps,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] mp_q, mp_d;
    logic [DATA_W-1:0] dl_q, dl_d;
    logic [CNT_W-1:0]  dc_q, dc_d;
    logic              err_q, err_d;

    logic              wr;
    logic              start_ok;
    logic              last_entry;
    logic              step_up;
    logic [DATA_W-1:0] step_next;

    assign wr         = valid_q & ~fifo_full & ~abort;
    assign last_entry = (cnt_q == CNT_W'(1));
    assign start_ok   = (min_period != '0) && (min_period <= start_period) &&
                        ((mode == MODE_UNIF) || ((mode == MODE_ADCEL) && (accel_steps != '0)));
    // the last accel write already produces the first decel word, so it steps upward
    assign step_up    = (state_q == ST_DECEL) || ((state_q == ST_ACCEL) && last_entry);

    period_step_sat #(.W(DATA_W)) u_step (
        .cur_i   (word_q),
        .delta_i (dl_q),
        .bound_i (step_up ? sp_q : mp_q),
        .up_i    (step_up),
        .next_o  (step_next)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        mp_d    = mp_q;
        dl_d    = dl_q;
        dc_d    = dc_q;
        err_d   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            sp_d    = start_period;
                            mp_d    = min_period;
                            dl_d    = delta;
                            dc_d    = decel_steps;
                            cnt_d   = accel_steps;
                            valid_d = 1'b1;
                            if (mode == MODE_UNIF) begin
                                word_d  = min_period;
                                state_d = ST_UNIF;
                            end else begin
                                word_d  = start_period;
                                state_d = ST_ACCEL;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_ACCEL: begin
                    if (wr) begin
                        if (last_entry && (dc_q == '0)) begin
                            valid_d = 1'b0;
                            state_d = ST_FIN;
                        end else if (last_entry) begin
                            cnt_d   = dc_q;
                            word_d  = step_next;
                            state_d = ST_DECEL;
                        end else begin
                            cnt_d  = cnt_q - CNT_W'(1);
                            word_d = step_next;
                        end
                    end
                end
                ST_DECEL: begin
                    if (wr) begin
                        if (last_entry) begin
                            valid_d = 1'b0;
                            state_d = ST_FIN;
                        end else begin
                            cnt_d  = cnt_q - CNT_W'(1);
                            word_d = step_next;
                        end
                    end
                end
                ST_UNIF: begin
                    if (wr) begin
                        valid_d = 1'b0;
                        state_d = ST_FIN;
                    end
                end
                ST_FIN:  state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            sp_q    <= '0;
            mp_q    <= '0;
            dl_q    <= '0;
            dc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            mp_q    <= mp_d;
            dl_q    <= dl_d;
            dc_q    <= dc_d;
            err_q   <= err_d;
        end
    end

    assign fifo_wr_en   = wr;
    assign fifo_wr_data = word_q;
    assign busy         = (state_q == ST_ACCEL) || (state_q == ST_DECEL) || (state_q == ST_UNIF);
    assign done         = (state_q == ST_FIN);
    assign err          = err_q;

endmodule

// File: tb/tb_ramp_table_writer.sv
// tb/tb_ramp_table_writer.sv - randomized and directed checks of ramp_table_writer against a table model
module tb_ramp_table_writer;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] start_period = '0;
    logic [DW-1:0] min_period = '0;
    logic [DW-1:0] delta = '0;
    logic [CW-1:0] accel_steps = '0;
    logic [CW-1:0] decel_steps = '0;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    ramp_table_writer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .start_period (start_period),
        .min_period   (min_period),
        .delta        (delta),
        .accel_steps  (accel_steps),
        .decel_steps  (decel_steps),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    int total = 0;
    int bad = 0;

    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];
    int done_cnt, err_cnt, err_cyc, first_wr_cyc, done_cyc, hold_bad, busy_bad, busy_hi;
    logic [DW-1:0] full_held;
    bit finished;

    // expected table straight from the closed-form word formulas; returns 0 when start is rejected
    function automatic bit model(input logic [1:0] m, input logic [DW-1:0] sp, input logic [DW-1:0] mp,
                                 input logic [DW-1:0] d, input logic [CW-1:0] a, input logic [CW-1:0] dc);
        longint v;
        longint p;
        exp_q.delete();
        if (mp == 0 || mp > sp) return 1'b0;
        if (!(m == 2'b10 || (m == 2'b01 && a != 0))) return 1'b0;
        if (m == 2'b10) begin
            exp_q.push_back(mp);
            return 1'b1;
        end
        p = 0;
        for (int i = 0; i < int'(a); i++) begin
            v = longint'(sp) - longint'(i) * longint'(d);
            if (v < longint'(mp)) v = longint'(mp);
            exp_q.push_back(v[DW-1:0]);
            p = v;
        end
        for (int j = 1; j <= int'(dc); j++) begin
            v = p + longint'(j) * longint'(d);
            if (v > longint'(sp)) v = longint'(sp);
            exp_q.push_back(v[DW-1:0]);
        end
        return 1'b1;
    endfunction

    task automatic do_start(input logic [1:0] m, input logic [DW-1:0] sp, input logic [DW-1:0] mp,
                            input logic [DW-1:0] d, input logic [CW-1:0] a, input logic [CW-1:0] dc);
        @(negedge clk);
        mode = m; start_period = sp; min_period = mp; delta = d; accel_steps = a; decel_steps = dc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // cycle 0 is the cycle right after the start edge; collects writes and status events
    task automatic run(input int max_cyc, input int abort_after, input int full_at, input int full_len,
                       input bit rand_full, input bit poke);
        logic [DW-1:0] held;
        int  full_left;
        bit  full_used;
        bit  prev_full;
        int  abort_cyc;
        held = '0; full_left = 0; full_used = 0; prev_full = 0; abort_cyc = -1;
        got.delete();
        done_cnt = 0; err_cnt = 0; err_cyc = -1; first_wr_cyc = -1; done_cyc = -1;
        hold_bad = 0; busy_bad = 0; busy_hi = 0; full_held = '0; finished = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            abort = 1'b0;
            if (abort_after >= 0 && abort_cyc < 0 && got.size() == abort_after) begin
                abort = 1'b1;
                abort_cyc = c;
            end
            if (poke && c == 3) begin
                start = 1'b1; mode = 2'b11; start_period = 7; min_period = 3; delta = 1;
            end
            if (poke && c == 4) start = 1'b0;
            if (!full_used && full_at >= 0 && got.size() == full_at) begin
                full_left = full_len;
                full_used = 1;
            end
            fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : (full_left > 0);
            if (full_left > 0) full_left--;
            #1;
            if (fifo_full) begin
                if (!prev_full) begin
                    held = fifo_wr_data;
                    if (full_held == '0) full_held = fifo_wr_data;
                end
                if (fifo_wr_en || fifo_wr_data !== held) hold_bad++;
            end
            prev_full = fifo_full;
            if (fifo_wr_en) begin
                if (got.size() == 0) first_wr_cyc = c;
                got.push_back(fifo_wr_data);
                if (!busy) busy_bad++;
            end
            if (busy) busy_hi++;
            if (err) begin err_cnt++; err_cyc = c; end
            if (busy && abort_cyc >= 0 && c > abort_cyc) busy_bad++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                if (busy) busy_bad++;
            end
            if (done || (abort_cyc >= 0 && c >= abort_cyc + 8)) begin
                finished = 1;
                break;
            end
        end
        abort = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset wr_en: got %b want 0", fifo_wr_en); end
        total++; if (fifo_wr_data !== '0) begin bad++; $display("FAIL reset wr_data: got %0d want 0", fifo_wr_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_profile();
        logic [1:0]    m[6]  = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
        logic [DW-1:0] sp[6] = '{1000, 500, 900, 1000, 32'hFFFF_FFF0, 300};
        logic [DW-1:0] mp[6] = '{400, 350, 250, 400, 1, 300};
        logic [DW-1:0] d[6]  = '{100, 100, 77, 100, 32'h8000_0000, 5};
        logic [CW-1:0] a[6]  = '{4, 4, 0, 3, 3, 1};
        logic [CW-1:0] dc[6] = '{3, 2, 0, 0, 3, 1};
        bit acc;
        for (int t = 0; t < 6; t++) begin
            acc = model(m[t], sp[t], mp[t], d[t], a[t], dc[t]);
            do_start(m[t], sp[t], mp[t], d[t], a[t], dc[t]);
            run(200, -1, -1, 0, 0, 0);
            total++; if (finished !== 1'b1 || !acc) begin bad++; $display("FAIL profile%0d finished: got %0d want 1", t, finished); end
            total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL profile%0d count: got %0d want %0d", t, got.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (k >= got.size() || got[k] !== exp_q[k]) begin
                    bad++; $display("FAIL profile%0d word%0d: got %0d want %0d", t, k, (k < got.size()) ? got[k] : '0, exp_q[k]);
                end
            end
            total++; if (first_wr_cyc != 0) begin bad++; $display("FAIL profile%0d first latency: got %0d want 0", t, first_wr_cyc); end
            total++; if (done_cyc != exp_q.size()) begin bad++; $display("FAIL profile%0d done cycle: got %0d want %0d", t, done_cyc, exp_q.size()); end
            total++; if (done_cnt != 1 || busy_bad != 0) begin bad++; $display("FAIL profile%0d done/busy: got %0d/%0d want 1/0", t, done_cnt, busy_bad); end
            @(negedge clk); #1;
            total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL profile%0d after done: got %b%b want 00", t, done, busy); end
        end
    endtask

    task automatic test_backpressure();
        void'(model(2'b01, 1000, 400, 100, 4, 3));
        do_start(2'b01, 1000, 400, 100, 4, 3);
        run(60, -1, 2, 5, 0, 0);
        total++; if (got.size() != 7) begin bad++; $display("FAIL bp count: got %0d want 7", got.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (k >= got.size() || got[k] !== exp_q[k]) begin
                bad++; $display("FAIL bp word%0d: got %0d want %0d", k, (k < got.size()) ? got[k] : '0, exp_q[k]);
            end
        end
        total++; if (full_held !== 800) begin bad++; $display("FAIL bp held word: got %0d want 800", full_held); end
        total++; if (hold_bad != 0) begin bad++; $display("FAIL bp hold: got %0d violations want 0", hold_bad); end
        total++; if (done_cyc != 12) begin bad++; $display("FAIL bp done cycle: got %0d want 12", done_cyc); end
    endtask

    task automatic test_reject();
        logic [1:0]    m[4]  = '{2'b01, 2'b11, 2'b10, 2'b01};
        logic [DW-1:0] sp[4] = '{500, 1000, 800, 800};
        logic [DW-1:0] mp[4] = '{600, 400, 0, 100};
        logic [CW-1:0] a[4]  = '{3, 3, 3, 0};
        for (int t = 0; t < 4; t++) begin
            do_start(m[t], sp[t], mp[t], 10, a[t], 2);
            run(6, -1, -1, 0, 0, 0);
            total++; if (err_cnt != 1 || err_cyc != 0) begin bad++; $display("FAIL reject%0d err: got %0d@%0d want 1@0", t, err_cnt, err_cyc); end
            total++; if (got.size() != 0 || done_cnt != 0 || busy_hi != 0) begin bad++; $display("FAIL reject%0d activity: got %0d/%0d/%0d want 0/0/0", t, got.size(), done_cnt, busy_hi); end
        end
    endtask

    task automatic test_abort();
        void'(model(2'b01, 1000, 400, 100, 4, 3));
        do_start(2'b01, 1000, 400, 100, 4, 3);
        run(40, 2, -1, 0, 0, 0);
        total++; if (got.size() != 2 || got[0] !== 1000 || got[1] !== 900) begin bad++; $display("FAIL abort writes: got %0d words want 2 (1000,900)", got.size()); end
        total++; if (done_cnt != 0 || busy_bad != 0) begin bad++; $display("FAIL abort done/busy: got %0d/%0d want 0/0", done_cnt, busy_bad); end
        do_start(2'b01, 1000, 400, 100, 4, 3);
        run(40, -1, -1, 0, 0, 0);
        total++; if (got.size() != 7 || done_cnt != 1) begin bad++; $display("FAIL abort restart: got %0d words %0d done want 7/1", got.size(), done_cnt); end
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (k >= got.size() || got[k] !== exp_q[k]) begin
                bad++; $display("FAIL restart word%0d: got %0d want %0d", k, (k < got.size()) ? got[k] : '0, exp_q[k]);
            end
        end
        @(negedge clk);
        mode = 2'b01; start_period = 1000; min_period = 400; delta = 100; accel_steps = 4; decel_steps = 3;
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        run(5, -1, -1, 0, 0, 0);
        total++; if (got.size() != 0 || busy_hi != 0 || err_cnt != 0) begin bad++; $display("FAIL start+abort: got %0d/%0d/%0d want 0/0/0", got.size(), busy_hi, err_cnt); end
    endtask

    task automatic test_busy_ignore();
        void'(model(2'b01, 1000, 400, 100, 4, 3));
        do_start(2'b01, 1000, 400, 100, 4, 3);
        run(40, -1, -1, 0, 0, 1);
        total++; if (got.size() != 7 || err_cnt != 0 || done_cnt != 1) begin bad++; $display("FAIL busy start: got %0d words err %0d want 7/0", got.size(), err_cnt); end
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (k >= got.size() || got[k] !== exp_q[k]) begin
                bad++; $display("FAIL busy word%0d: got %0d want %0d", k, (k < got.size()) ? got[k] : '0, exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_start(2'b01, 1000, 400, 100, 4, 3);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || fifo_wr_data !== '0) begin bad++; $display("FAIL mid reset: got en=%b busy=%b data=%0d want 0/0/0", fifo_wr_en, busy, fifo_wr_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0]    m;
        logic [DW-1:0] sp, mp, d;
        logic [CW-1:0] a, dc;
        int r;
        bit acc;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            m = (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                sp = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
                mp = 32'($urandom_range(1, 3000));
                d  = $urandom();
            end else begin
                sp = 32'($urandom_range(1, 5000));
                mp = 32'($urandom_range(0, 5200));
                d  = 32'($urandom_range(0, 900));
            end
            a  = CW'($urandom_range(0, 12));
            dc = CW'($urandom_range(0, 12));
            acc = model(m, sp, mp, d, a, dc);
            do_start(m, sp, mp, d, a, dc);
            run(acc ? 300 : 6, -1, -1, 0, 1, 0);
            total++; if (err_cnt != (acc ? 0 : 1)) begin bad++; $display("FAIL rand%0d err: got %0d want %0d", t, err_cnt, acc ? 0 : 1); end
            total++; if (finished != acc || done_cnt != (acc ? 1 : 0)) begin bad++; $display("FAIL rand%0d done: got %0d want %0d", t, done_cnt, acc ? 1 : 0); end
            total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d count: got %0d want %0d", t, got.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (k >= got.size() || got[k] !== exp_q[k]) begin
                    bad++; $display("FAIL rand%0d word%0d: got %0d want %0d", t, k, (k < got.size()) ? got[k] : '0, exp_q[k]);
                end
            end
            total++; if (hold_bad != 0 || busy_bad != 0) begin bad++; $display("FAIL rand%0d hold/busy: got %0d/%0d want 0/0", t, hold_bad, busy_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_profile();
        test_backpressure();
        test_reject();
        test_abort();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
